// File: rtl/fifo_ptr_ctrl_if.sv
// Request/status bundle between a FIFO user and the asymmetric-width pointer controller.
// The master side issues push/pop requests; the controller (slave) drives RAM addressing and flags.
interface fifo_ptr_ctrl_if #(
    parameter int RAM_ADDR_WIDTH = 6,
    parameter int WR_L2          = 2,
    parameter int RD_L2          = 3
);
    logic                              wr_en;
    logic                              rd_en;
    logic                              ram_wr_en;
    logic [RAM_ADDR_WIDTH-1:0]         ram_wr_addr;
    logic [RAM_ADDR_WIDTH-1:0]         ram_rd_addr;
    logic                              rd_valid;
    logic                              full;
    logic                              empty;
    logic                              almost_full;
    logic                              almost_empty;
    logic [RAM_ADDR_WIDTH-WR_L2:0]     wr_count;
    logic [RAM_ADDR_WIDTH-RD_L2:0]     rd_count;
    logic                              overflow;
    logic                              underflow;

    modport master (
        output wr_en, rd_en,
        input  ram_wr_en, ram_wr_addr, ram_rd_addr, rd_valid, full, empty,
               almost_full, almost_empty, wr_count, rd_count, overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en,
        output ram_wr_en, ram_wr_addr, ram_rd_addr, rd_valid, full, empty,
               almost_full, almost_empty, wr_count, rd_count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Single-clock pointer and flag controller for a width-converting FIFO RAM.
// Pointers count RAM units and carry one extra wrap bit; flags/counts are registered from next-state pointers.
module fifo_ptr_ctrl #(
    parameter int RAM_DEPTH      = 64,
    parameter int RAM_ADDR_WIDTH = 6,
    parameter int WR_WIDTH       = 32,
    parameter int RD_WIDTH       = 64,
    parameter int RAM_WIDTH      = 8,
    parameter int WR_L2          = 2,
    parameter int RD_L2          = 3,
    parameter int AF_THRESH      = 14,
    parameter int AE_THRESH      = 1
) (
    input  logic           clk,
    input  logic           rst,
    fifo_ptr_ctrl_if.slave bus
);
    localparam int PW  = RAM_ADDR_WIDTH + 1;
    localparam int WCW = RAM_ADDR_WIDTH - WR_L2 + 1;
    localparam int RCW = RAM_ADDR_WIDTH - RD_L2 + 1;
    localparam logic [PW-1:0] WR_STEP = PW'(1 << WR_L2);
    localparam logic [PW-1:0] RD_STEP = PW'(1 << RD_L2);

    if ((WR_WIDTH != (RAM_WIDTH << WR_L2)) || (RD_WIDTH != (RAM_WIDTH << RD_L2)) ||
        (RAM_DEPTH != (1 << RAM_ADDR_WIDTH))) begin : g_cfg_check
        $error("fifo_ptr_ctrl: inconsistent width/depth parameters");
    end

    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic           r_full;
    logic           r_empty;
    logic           r_almost_full;
    logic           r_almost_empty;
    logic [WCW-1:0] r_wr_count;
    logic [RCW-1:0] r_rd_count;
    logic           r_overflow;
    logic           r_underflow;
    logic           r_rd_valid;

    logic           w_push;
    logic           w_pop;
    logic [PW-1:0]  w_wr_ptr_nxt;
    logic [PW-1:0]  w_rd_ptr_nxt;
    logic [PW-1:0]  w_occ_nxt;
    logic [PW-1:0]  w_free_nxt;
    logic [WCW-1:0] w_wr_count_nxt;
    logic [RCW-1:0] w_rd_count_nxt;

    // Each request is judged only against the registered flags, so a same-cycle
    // pop cannot make room for a push and a same-cycle push cannot feed a pop.
    assign w_push = bus.wr_en & ~r_full;
    assign w_pop  = bus.rd_en & ~r_empty;

    assign w_wr_ptr_nxt   = w_push ? r_wr_ptr + WR_STEP : r_wr_ptr;
    assign w_rd_ptr_nxt   = w_pop  ? r_rd_ptr + RD_STEP : r_rd_ptr;
    assign w_occ_nxt      = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_free_nxt     = PW'(RAM_DEPTH) - w_occ_nxt;
    assign w_wr_count_nxt = w_occ_nxt[PW-1:WR_L2];
    assign w_rd_count_nxt = w_occ_nxt[PW-1:RD_L2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_wr_count     <= '0;
            r_rd_count     <= '0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_rd_valid     <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_full         <= (w_free_nxt < WR_STEP);
            r_empty        <= (w_occ_nxt < RD_STEP);
            r_almost_full  <= (w_wr_count_nxt >= WCW'(AF_THRESH));
            r_almost_empty <= (w_rd_count_nxt <= RCW'(AE_THRESH));
            r_wr_count     <= w_wr_count_nxt;
            r_rd_count     <= w_rd_count_nxt;
            r_overflow     <= bus.wr_en & r_full;
            r_underflow    <= bus.rd_en & r_empty;
            r_rd_valid     <= w_pop;
        end
    end

    assign bus.ram_wr_en    = w_push;
    assign bus.ram_wr_addr  = r_wr_ptr[RAM_ADDR_WIDTH-1:0];
    assign bus.ram_rd_addr  = r_rd_ptr[RAM_ADDR_WIDTH-1:0];
    assign bus.rd_valid     = r_rd_valid;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.wr_count     = r_wr_count;
    assign bus.rd_count     = r_rd_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl with a behavioural byte RAM and an in-order data scoreboard.
// Directed phases use hand-computed constants; the wrap phase checks against a small occupancy model.
module tb_fifo_ptr_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_ptr_ctrl_if #(.RAM_ADDR_WIDTH(6), .WR_L2(2), .RD_L2(3)) bus ();

    fifo_ptr_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  mem [64];
    logic [7:0]  q [$];
    logic [7:0]  seq;
    logic [63:0] rdata;

    logic [6:0] m_wp, m_rp;
    logic       m_full, m_empty, m_rv, m_ovf, m_unf;
    bit         mcheck;
    int         nwrap_w, nwrap_r;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wp = '0; m_rp = '0;
        m_full = 1'b0; m_empty = 1'b1;
        m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        q.delete();
    endtask

    task automatic settle();
        #2;
    endtask

    // One clock: sample combinational outputs at negedge, emulate the RAM at posedge, check at posedge+1.
    task automatic cycle();
        logic        we, wr_s, rd_s, p_push, p_pop;
        logic [5:0]  wa, ra, ix;
        logic [31:0] wd;
        logic [63:0] expd;
        logic [6:0]  occ;
        @(negedge clk);
        we   = bus.ram_wr_en;
        wa   = bus.ram_wr_addr;
        ra   = bus.ram_rd_addr;
        wr_s = bus.wr_en;
        rd_s = bus.rd_en;
        wd   = {seq + 8'd3, seq + 8'd2, seq + 8'd1, seq};
        p_push = wr_s && !m_full;
        p_pop  = rd_s && !m_empty;
        if (mcheck) begin
            chk("m_ram_wr_en", 64'(we), 64'(p_push));
            chk("m_wr_addr", 64'(wa), 64'(m_wp[5:0]));
            chk("m_rd_addr", 64'(ra), 64'(m_rp[5:0]));
        end
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            ix = ra + 6'(k);
            rdata[8*k +: 8] = mem[ix];
        end
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                ix = wa + 6'(k);
                mem[ix] = wd[8*k +: 8];
                q.push_back(wd[8*k +: 8]);
            end
            seq = seq + 8'd4;
        end
        if (!rst) begin
            m_ovf = wr_s && m_full;
            m_unf = rd_s && m_empty;
            m_rv  = p_pop;
            if (p_push) begin
                if (m_wp[5:0] == 6'd60) nwrap_w++;
                m_wp = m_wp + 7'd4;
            end
            if (p_pop) begin
                if (m_rp[5:0] == 6'd56) nwrap_r++;
                m_rp = m_rp + 7'd8;
            end
            occ     = m_wp - m_rp;
            m_full  = (7'd64 - occ) < 7'd4;
            m_empty = occ < 7'd8;
        end
        #1;
        if (bus.rd_valid) begin
            if (q.size() >= 8) begin
                for (int k = 0; k < 8; k++) expd[8*k +: 8] = q.pop_front();
                chk("rd_data", rdata, expd);
            end else begin
                chk("rd_data_avail", 64'(q.size()), 64'd8);
            end
        end
        if (mcheck) begin
            occ = m_wp - m_rp;
            chk("m_full", 64'(bus.full), 64'(m_full));
            chk("m_empty", 64'(bus.empty), 64'(m_empty));
            chk("m_wr_count", 64'(bus.wr_count), 64'(occ >> 2));
            chk("m_rd_count", 64'(bus.rd_count), 64'(occ >> 3));
            chk("m_almost_full", 64'(bus.almost_full), 64'((occ >> 2) >= 7'd14));
            chk("m_almost_empty", 64'(bus.almost_empty), 64'((occ >> 3) <= 7'd1));
            chk("m_rd_valid", 64'(bus.rd_valid), 64'(m_rv));
            chk("m_overflow", 64'(bus.overflow), 64'(m_ovf));
            chk("m_underflow", 64'(bus.underflow), 64'(m_unf));
            chk("m_counts_bound", 64'((bus.wr_count <= 5'd16) && (bus.rd_count <= 4'd8)), 64'd1);
        end
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_empty"}, 64'(bus.empty), 64'd1);
        chk({pfx, "_almost_empty"}, 64'(bus.almost_empty), 64'd1);
        chk({pfx, "_full"}, 64'(bus.full), 64'd0);
        chk({pfx, "_almost_full"}, 64'(bus.almost_full), 64'd0);
        chk({pfx, "_wr_count"}, 64'(bus.wr_count), 64'd0);
        chk({pfx, "_rd_count"}, 64'(bus.rd_count), 64'd0);
        chk({pfx, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
        chk({pfx, "_wr_addr"}, 64'(bus.ram_wr_addr), 64'd0);
        chk({pfx, "_rd_addr"}, 64'(bus.ram_rd_addr), 64'd0);
        chk({pfx, "_overflow"}, 64'(bus.overflow), 64'd0);
        chk({pfx, "_underflow"}, 64'(bus.underflow), 64'd0);
    endtask

    initial begin
        int guard;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        seq = 8'd0;
        mcheck = 1'b0;
        nwrap_w = 0;
        nwrap_r = 0;
        rdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'd0;
        model_reset();

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_state("por");

        // Fill: 16 pushes, addresses 0,4,...,60
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1;
            settle();
            chk("fill_ram_wr_en", 64'(bus.ram_wr_en), 64'd1);
            chk("fill_wr_addr", 64'(bus.ram_wr_addr), 64'(i * 4));
            cycle();
            chk("fill_wr_count", 64'(bus.wr_count), 64'(i + 1));
            chk("fill_rd_count", 64'(bus.rd_count), 64'((i + 1) / 2));
            chk("fill_empty", 64'(bus.empty), 64'(i == 0));
            chk("fill_full", 64'(bus.full), 64'(i == 15));
            chk("fill_almost_full", 64'(bus.almost_full), 64'(i >= 13));
        end
        // 17th push is rejected
        settle();
        chk("ovf_ram_wr_en", 64'(bus.ram_wr_en), 64'd0);
        cycle();
        chk("ovf_pulse", 64'(bus.overflow), 64'd1);
        chk("ovf_wr_addr", 64'(bus.ram_wr_addr), 64'd0);
        chk("ovf_wr_count", 64'(bus.wr_count), 64'd16);
        chk("ovf_full", 64'(bus.full), 64'd1);

        // Full with simultaneous push and pop: push rejected, pop accepted
        bus.rd_en = 1'b1;
        settle();
        chk("fp_ram_wr_en", 64'(bus.ram_wr_en), 64'd0);
        chk("fp_rd_addr", 64'(bus.ram_rd_addr), 64'd0);
        cycle();
        chk("fp_overflow", 64'(bus.overflow), 64'd1);
        chk("fp_rd_valid", 64'(bus.rd_valid), 64'd1);
        chk("fp_wr_count", 64'(bus.wr_count), 64'd14);
        chk("fp_rd_count", 64'(bus.rd_count), 64'd7);
        chk("fp_full", 64'(bus.full), 64'd0);
        chk("fp_almost_full", 64'(bus.almost_full), 64'd1);

        // Drain the remaining 7 read words
        bus.wr_en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            settle();
            chk("drain_rd_addr", 64'(bus.ram_rd_addr), 64'(8 * (k + 1)));
            cycle();
            chk("drain_rd_valid", 64'(bus.rd_valid), 64'd1);
            chk("drain_rd_count", 64'(bus.rd_count), 64'(6 - k));
            chk("drain_wr_count", 64'(bus.wr_count), 64'(2 * (6 - k)));
            chk("drain_overflow", 64'(bus.overflow), 64'd0);
        end
        chk("drain_empty", 64'(bus.empty), 64'd1);

        // Underflow
        cycle();
        chk("unf_pulse", 64'(bus.underflow), 64'd1);
        chk("unf_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("unf_rd_addr", 64'(bus.ram_rd_addr), 64'd0);
        bus.rd_en = 1'b0;
        cycle();
        chk("unf_clear", 64'(bus.underflow), 64'd0);

        // Granularity: one write word is not a read word
        bus.wr_en = 1'b1;
        cycle();
        chk("gr1_empty", 64'(bus.empty), 64'd1);
        chk("gr1_rd_count", 64'(bus.rd_count), 64'd0);
        chk("gr1_wr_count", 64'(bus.wr_count), 64'd1);
        // Second push together with a pop: the pop still sees empty
        bus.rd_en = 1'b1;
        settle();
        chk("gr2_ram_wr_en", 64'(bus.ram_wr_en), 64'd1);
        cycle();
        chk("gr2_empty", 64'(bus.empty), 64'd0);
        chk("gr2_rd_count", 64'(bus.rd_count), 64'd1);
        chk("gr2_underflow", 64'(bus.underflow), 64'd1);
        chk("gr2_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("gr2_almost_empty", 64'(bus.almost_empty), 64'd1);
        bus.wr_en = 1'b0;
        settle();
        chk("gr3_rd_addr", 64'(bus.ram_rd_addr), 64'd0);
        cycle();
        chk("gr3_rd_valid", 64'(bus.rd_valid), 64'd1);
        chk("gr3_empty", 64'(bus.empty), 64'd1);
        chk("gr3_rd_count", 64'(bus.rd_count), 64'd0);
        chk("gr3_rd_addr_next", 64'(bus.ram_rd_addr), 64'd8);
        bus.rd_en = 1'b0;

        // Mid-stream asynchronous reset with a read in flight
        bus.wr_en = 1'b1;
        cycle();
        cycle();
        bus.rd_en = 1'b1;
        cycle();
        chk("mid_rd_valid_pre", 64'(bus.rd_valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_state("mid");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b1;
        cycle();
        chk("rel_wr_count", 64'(bus.wr_count), 64'd1);
        chk("rel_wr_addr", 64'(bus.ram_wr_addr), 64'd4);
        bus.wr_en = 1'b0;

        // Wrap: fill/drain rounds with random gaps, checked against the occupancy model
        mcheck = 1'b1;
        for (int r = 0; r < 3; r++) begin
            guard = 0;
            while (!m_full && guard < 400) begin
                bus.wr_en = ($urandom_range(0, 9) < 7);
                bus.rd_en = ($urandom_range(0, 9) < 2);
                cycle();
                guard++;
            end
            chk("wrap_fill_done", 64'(m_full), 64'd1);
            guard = 0;
            while (!m_empty && guard < 400) begin
                bus.wr_en = ($urandom_range(0, 9) < 1);
                bus.rd_en = ($urandom_range(0, 9) < 7);
                cycle();
                guard++;
            end
            chk("wrap_drain_done", 64'(m_empty), 64'd1);
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        cycle();
        chk("wrap_wr_seen", 64'(nwrap_w >= 2), 64'd1);
        chk("wrap_rd_seen", 64'(nwrap_r >= 2), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
